// File: rtl/results_uart_streamer.sv
// rtl/results_uart_streamer.sv - streams predicted digit and class scores from the result RAMs to uart_tx
module results_uart_streamer #(
  parameter int         NUM_SCORES      = 10,
  parameter int         BYTES_PER_SCORE = 4,
  parameter int         SEND_HEADER     = 1,
  parameter logic [7:0] HEADER_BYTE     = 8'hAA
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       digit_rd_addr,
  input  logic [7:0] digit_rd_data,
  output logic [5:0] score_rd_addr,
  input  logic [7:0] score_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done
);

  localparam int         FRAME_LEN  = SEND_HEADER + 1 + NUM_SCORES * BYTES_PER_SCORE;
  localparam logic [5:0] LAST_IDX   = 6'(FRAME_LEN - 1);
  localparam logic [5:0] DIGIT_IDX  = 6'(SEND_HEADER);
  localparam logic [5:0] SCORE_BASE = 6'(SEND_HEADER + 1);
  localparam bit         HAS_HEADER = (SEND_HEADER != 0);

  typedef enum logic [2:0] {
    IDLE, FETCH, RAMWAIT, LOAD, SEND, WAIT_HI, WAIT_LO, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] idx;
  logic       is_header;
  logic       in_frame;

  assign is_header     = HAS_HEADER && (idx == 6'd0);
  assign in_frame      = (state != IDLE) && (state != DONE);
  assign digit_rd_addr = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      // the header is a constant, so it skips the RAM read latency
      FETCH:   state_nxt = is_header ? LOAD : RAMWAIT;
      RAMWAIT: state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (!tx_busy) state_nxt = WAIT_HI;
      WAIT_HI: if (tx_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= 6'd0;
      tx_data <= 8'd0;
    end else begin
      if (state == IDLE && start)
        idx <= 6'd0;
      else if (state == WAIT_LO && !tx_busy && idx != LAST_IDX)
        idx <= idx + 6'd1;
      if (state == LOAD) begin
        if (is_header)              tx_data <= HEADER_BYTE;
        else if (idx == DIGIT_IDX)  tx_data <= digit_rd_data;
        else                        tx_data <= score_rd_data;
      end
    end
  end

  // score address stays put for the whole byte so the RAM output is stable at LOAD
  always_comb begin
    tx_start      = (state == SEND) && !tx_busy;
    busy          = in_frame;
    done          = (state == DONE);
    score_rd_addr = 6'd0;
    if (in_frame && idx >= SCORE_BASE)
      score_rd_addr = idx - SCORE_BASE;
  end

endmodule

// File: tb/tb_results_uart_streamer.sv
// tb/tb_results_uart_streamer.sv - scoreboard bench for results_uart_streamer (header and headerless builds)
module tb_results_uart_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0, force_busy0 = 1'b0;
  logic       d0_addr, d1_addr;
  logic [7:0] d0_data, d1_data, s0_data, s1_data;
  logic [5:0] s0_addr, s1_addr;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_start0, tx_start1, busy0, busy1, done0, done1;
  logic       tx_busy0, tx_busy1;

  logic [7:0] digit_mem;
  logic [7:0] score_mem [40];
  int         cnt0 = 0, cnt1 = 0;
  int         checks = 0, errors = 0, cyc = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         bytes0 = 0, bytes1 = 0, dones0 = 0, dones1 = 0, first0 = 0, first1 = 0;
  logic       prev0 = 1'b0, prev1 = 1'b0;
  int         t0, d;

  results_uart_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .digit_rd_addr(d0_addr), .digit_rd_data(d0_data),
    .score_rd_addr(s0_addr), .score_rd_data(s0_data),
    .tx_data(tx_data0), .tx_start(tx_start0), .tx_busy(tx_busy0),
    .busy(busy0), .done(done0)
  );

  results_uart_streamer #(.SEND_HEADER(0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .digit_rd_addr(d1_addr), .digit_rd_data(d1_data),
    .score_rd_addr(s1_addr), .score_rd_data(s1_data),
    .tx_data(tx_data1), .tx_start(tx_start1), .tx_busy(tx_busy1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // registered-read RAM models
  always @(posedge clk) begin
    d0_data <= digit_mem;
    d1_data <= digit_mem;
    s0_data <= (s0_addr < 6'd40) ? score_mem[s0_addr] : 8'h00;
    s1_data <= (s1_addr < 6'd40) ? score_mem[s1_addr] : 8'h00;
  end

  // uart_tx models: busy for 10 cycles after each tx_start
  assign tx_busy0 = (cnt0 != 0) || force_busy0;
  assign tx_busy1 = (cnt1 != 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 0;
      cnt1 <= 0;
    end else begin
      if (tx_start0) cnt0 <= 10; else if (cnt0 != 0) cnt0 <= cnt0 - 1;
      if (tx_start1) cnt1 <= 10; else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start0) begin
      if (bytes0 == 0) first0 = cyc;
      check("tx_start_width0", {31'd0, prev0}, 0);
      check("byte_expected0", (q0.size() != 0), 1);
      if (q0.size() != 0) check("byte0", tx_data0, q0.pop_front());
      bytes0++;
    end
    prev0 = tx_start0;
    if (done0) begin
      dones0++;
      check("busy_at_done0", busy0, 0);
      check("frame_left0", q0.size(), 0);
    end
  end

  always @(negedge clk) begin
    if (tx_start1) begin
      if (bytes1 == 0) first1 = cyc;
      check("tx_start_width1", {31'd0, prev1}, 0);
      check("byte_expected1", (q1.size() != 0), 1);
      if (q1.size() != 0) check("byte1", tx_data1, q1.pop_front());
      bytes1++;
    end
    prev1 = tx_start1;
    if (done1) begin
      dones1++;
      check("busy_at_done1", busy1, 0);
      check("frame_left1", q1.size(), 0);
    end
  end

  task automatic push_exp(input int which);
    if (which == 0) begin
      q0.push_back(8'hAA);
      q0.push_back(digit_mem);
      for (int a = 0; a < 40; a++) q0.push_back(score_mem[a]);
    end else begin
      q1.push_back(digit_mem);
      for (int a = 0; a < 40; a++) q1.push_back(score_mem[a]);
    end
  endtask

  task automatic pulse(input int which, output int t_start);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    t_start = cyc;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done0(input int dbase);
    for (int i = 0; i < 3000 && dones0 == dbase; i++) @(negedge clk);
    check("done_seen0", dones0 - dbase, 1);
    repeat (5) @(negedge clk);
    check("done_count0", dones0 - dbase, 1);
    check("frame_len0", bytes0, 42);
  endtask

  task automatic run_frame0(input int restart_at, input int hold, input bit chk_lat);
    int ts, db;
    push_exp(0);
    bytes0 = 0;
    db = dones0;
    force_busy0 = (hold > 0);
    pulse(0, ts);
    @(negedge clk);
    check("busy_after_start0", busy0, 1);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("no_tx_while_busy", bytes0, 0);
      check("stalled_busy", busy0, 1);
      force_busy0 = 1'b0;
    end
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    wait_done0(db);
    if (chk_lat) check("latency_hdr", first0 - ts + 1, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    digit_mem = 8'd0;
    for (int a = 0; a < 40; a++) score_mem[a] = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", tx_data0, 0);
    check("rst_tx_start", tx_start0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_score_addr", s0_addr, 0);
    check("rst_digit_addr", d0_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // score_k = k*256 + k, digit 7
    digit_mem = 8'd7;
    for (int k = 0; k < 10; k++) begin
      score_mem[4*k]   = 8'(k);
      score_mem[4*k+1] = 8'(k);
      score_mem[4*k+2] = 8'h00;
      score_mem[4*k+3] = 8'h00;
    end
    run_frame0(0, 0, 1'b1);

    // score_3 = -2
    digit_mem = 8'd3;
    for (int a = 0; a < 40; a++) score_mem[a] = 8'h00;
    score_mem[12] = 8'hFE;
    score_mem[13] = 8'hFF;
    score_mem[14] = 8'hFF;
    score_mem[15] = 8'hFF;
    run_frame0(0, 0, 1'b0);

    // restart mid-frame is ignored
    digit_mem = 8'd5;
    for (int a = 0; a < 40; a++) score_mem[a] = 8'($urandom_range(0, 255));
    run_frame0(20, 0, 1'b0);

    // tx_busy stuck high before the first byte
    run_frame0(0, 500, 1'b0);

    // async reset after byte 10
    push_exp(0);
    bytes0 = 0;
    d = dones0;
    pulse(0, t0);
    for (int i = 0; i < 3000 && bytes0 < 11; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx_start", tx_start0, 0);
    check("abort_tx_data", tx_data0, 0);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_score_addr", s0_addr, 0);
    q0.delete();
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", dones0 - d, 0);
    run_frame0(0, 0, 1'b1);

    // headerless build
    digit_mem = 8'd9;
    for (int a = 0; a < 40; a++) score_mem[a] = 8'($urandom_range(0, 255));
    push_exp(1);
    bytes1 = 0;
    d = dones1;
    pulse(1, t0);
    for (int i = 0; i < 3000 && dones1 == d; i++) @(negedge clk);
    check("done_seen1", dones1 - d, 1);
    repeat (5) @(negedge clk);
    check("done_count1", dones1 - d, 1);
    check("frame_len1", bytes1, 41);
    check("latency_nohdr", first1 - t0 + 1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/results_uart_streamer.md
Name: results_uart_streamer

Overview:
- Reads the inference results out of `predicted_digit_ram` and `scores_ram` and serialises them into a byte frame for the UART transmitter.
- Sits between the result RAMs and `uart_tx`. It is the read end of the result memories, whose write end is the inference core.
- Triggered by a start pulse, normally a delayed `inference_done` or a host "read results" command. It accounts for the 1-cycle synchronous RAM read latency and paces bytes using `tx_busy`.

Parameters:
- NUM_SCORES, 10, number of class scores in `scores_ram`.
- BYTES_PER_SCORE, 4, bytes per score (little-endian in RAM).
- SEND_HEADER, 1, 1 = prepend HEADER_BYTE to the frame; 0 = no header.
- HEADER_BYTE, 8'hAA, frame sync byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to send a frame; ignored while busy=1.
- digit_rd_addr  out  1  read address to `predicted_digit_ram`, constant 0.
- digit_rd_data  in  8  registered read data from `predicted_digit_ram`.
- score_rd_addr  out  6  read address to `scores_ram`, range 0..39.
- score_rd_data  in  8  registered read data from `scores_ram`.
- tx_data  out  8  byte to `uart_tx`; held stable from tx_start until the byte completes.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  in  1  high while `uart_tx` is shifting a byte.
- busy  out  1  high from the cycle after an accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last byte has finished.

Behaviour:
- Frame order: [HEADER_BYTE if SEND_HEADER], digit byte, then score bytes at `scores_ram` addresses 0..39 in ascending order.
  - FRAME_LEN = SEND_HEADER + 1 + NUM_SCORES*BYTES_PER_SCORE, i.e. 42 with defaults.
- Byte index counter `idx`, 6 bits, runs 0..FRAME_LEN-1.
  - Score address = idx - SEND_HEADER - 1.
  - score_rd_addr is held at 0 outside the score phase.
  - digit_rd_addr is tied to 0.
- Reset (async, rst_n=0) values:
  - tx_data=0, tx_start=0, busy=0, done=0, score_rd_addr=0.
  - FSM in IDLE, idx=0.
- FSM states:
  - IDLE: busy=0. On start, idx←0, go to FETCH.
  - FETCH: drive the address for byte idx, held for 1 cycle. The header byte needs no read and goes straight to LOAD.
  - RAMWAIT: 1 cycle. RAM data becomes valid at the end of this cycle.
  - LOAD: tx_data ← HEADER_BYTE, digit_rd_data, or score_rd_data, as selected by idx. Go to SEND.
  - SEND: tx_start=1 for exactly 1 cycle, and only if tx_busy=0. Otherwise stay in SEND with tx_start=0.
  - WAIT_HI: wait until tx_busy=1, which marks acceptance. No timeout.
  - WAIT_LO: wait until tx_busy=0.
    - If idx=FRAME_LEN-1, go to DONE.
    - Otherwise idx←idx+1 and go to FETCH.
  - DONE: done=1 for 1 cycle, busy←0, return to IDLE.
- Latency:
  - start to first tx_start is 3 cycles with a header (FETCH, LOAD, SEND); the header path skips RAMWAIT.
  - start to first tx_start is 4 cycles without a header.
  - tx_busy falling to the next tx_start is 4 cycles (FETCH, RAMWAIT, LOAD, SEND).
- Overlaps and simultaneous events:
  - start while busy=1 is ignored, with no queuing.
  - start in the same cycle as done: done wins and start is ignored.
- Sampling: RAM contents are sampled byte by byte during the frame. The caller guarantees that `scores_ram` and `predicted_digit_ram` are not rewritten while busy=1.
- tx_data is only updated in LOAD, never while `uart_tx` is busy.
- rst_n asserted mid-frame aborts immediately:
  - tx_start drops to 0.
  - No done pulse is generated.
  - The next start after release sends a complete frame from the header.
- tx_busy already high when start arrives: the FSM proceeds through FETCH/LOAD and stalls in SEND until tx_busy=0.

Test Plan:
1. Scores RAM holds score_k = k*256+k; digit RAM holds 7; pulse start with tx_busy modelled as 10 cycles high after each tx_start → exactly 42 tx_start pulses, in this byte order:
   - AA, 07
   - 00 00 00 00
   - 01 01 00 00
   - … through 09 09 00 00
   - done pulses once and busy falls in the same cycle.
2. score_3 = -2, all other scores 0 → frame bytes 14..17 (0-based) are FE FF FF FF.
3. start pulsed again 20 cycles into a frame → ignored; exactly 42 bytes in total and a single done pulse.
4. tx_busy held high for 500 cycles before the first byte → no tx_start until tx_busy=0, then tx_data=AA with tx_start asserted for exactly 1 cycle.
5. rst_n pulled low after byte 10 → all outputs return to reset values asynchronously and no done pulse occurs; a new start sends a full 42-byte frame beginning with AA.
6. SEND_HEADER=0 → 41-byte frame starting with the digit byte; first tx_start occurs 4 cycles after start.
